// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs a single-outstanding
// request/response handshake with the instruction bus. The stage presents
// {pc, inst, valid} to the IF/ID register, and an invalid cycle presents zeros.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_adel_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        adel_q, adel_d;
  logic        discard_q, discard_d;
  logic        misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      adel_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state     <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      adel_q    <= adel_d;
      discard_q <= discard_d;
    end
  end

  // Next-state and output decode. In S_DONE, a redirect takes priority over a stall, and a stall takes priority over an advance.
  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    inst_d      = inst_q;
    adel_d      = adel_q;
    discard_d   = discard_q;
    inst_req_o  = 1'b0;
    inst_addr_o = pc_q;
    if_valid_o  = 1'b0;
    if_pc_o     = 32'd0;
    if_inst_o   = 32'd0;
    if_adel_o   = 1'b0;

    case (state)
      S_REQ: begin
        if (misaligned) begin
          // A misaligned PC never reaches the bus. A redirect in the same cycle still wins.
          if (branch_valid_i) begin
            pc_d = branch_target_i;
          end else begin
            adel_d  = 1'b1;
            inst_d  = 32'd0;
            state_d = S_DONE;
          end
        end else begin
          inst_req_o = 1'b1;
          if (branch_valid_i) pc_d = branch_target_i;
          if (inst_addr_ok_i) begin
            state_d = S_WAIT;
            // The accepted fetch belongs to the old path, so drop its data.
            if (branch_valid_i) discard_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (branch_valid_i) begin
          pc_d      = branch_target_i;
          discard_d = 1'b1;
        end
        if (inst_data_ok_i) begin
          if (discard_q || branch_valid_i) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            inst_d  = inst_rdata_i;
            adel_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if_valid_o = !branch_valid_i;
        if (!branch_valid_i) begin
          if_pc_o   = pc_q;
          if_inst_o = inst_q;
          if_adel_o = adel_q;
        end
        if (branch_valid_i) begin
          pc_d    = branch_target_i;
          adel_d  = 1'b0;
          state_d = S_REQ;
        end else if (!stall_i) begin
          pc_d    = pc_q + 32'd4;
          adel_d  = 1'b0;
          state_d = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase

    // While reset is held, every output is quiet except the address.
    if (!rst_i) begin
      inst_req_o = 1'b0;
      if_valid_o = 1'b0;
      if_pc_o    = 32'd0;
      if_inst_o  = 32'd0;
      if_adel_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit. A bus model serves fetches from a small
// table. Expected requests and presentations are queued ahead of time, and two
// monitors pop them as the DUT emits them.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } out_t;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, branch_valid_i;
  logic [31:0] branch_target_i;
  logic        inst_req_o, inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_addr_o, inst_rdata_i;
  logic        if_valid_o, if_adel_o;
  logic [31:0] if_pc_o, if_inst_o;

  int vectors = 0, miscompares = 0;
  logic [31:0] exp_req[$];
  out_t        exp_out[$];
  int hold_cfg = 0, hold_left = 0, data_lat = 1;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .branch_valid_i(branch_valid_i), .branch_target_i(branch_target_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_adel_o(if_adel_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: mem = 32'h2408_0001;
      32'hBFC0_0004: mem = 32'hDEAD_BEEF;
      32'hBFC0_0100: mem = 32'h3C01_1234;
      32'hBFC0_0104: mem = 32'h8C22_0008;
      32'hFFFF_FFFC: mem = 32'h1000_FFFF;
      32'h0000_0000: mem = 32'h2402_0000;
      32'h0000_0004: mem = 32'h2042_0001;
      default:       mem = 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin @(negedge clk_i); #2; n++; end while (!if_valid_o && n < 30);
    chk("wait_valid", {31'd0, if_valid_o}, 32'd1);
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk_i); #2; n++; end while (!(inst_req_o && inst_addr_ok_i) && n < 30);
    chk("wait_accept", {31'd0, inst_req_o && inst_addr_ok_i}, 32'd1);
  endtask

  // Bus model: addr_ok after hold_left request cycles, data_ok data_lat cycles after acceptance.
  initial begin : bus
    bit pending;
    int dcnt;
    logic [31:0] acc_addr, paddr;
    pending = 0; dcnt = 0; acc_addr = 0; paddr = 0;
    inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = 0;
    forever begin
      @(negedge clk_i); #1;
      if (!rst_i) begin
        pending = 0; inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = 0;
        hold_left = hold_cfg;
      end else begin
        if (inst_addr_ok_i) begin pending = 1; paddr = acc_addr; dcnt = data_lat; end
        inst_addr_ok_i = 0; inst_data_ok_i = 0; inst_rdata_i = 0;
        if (pending) begin
          dcnt--;
          if (dcnt <= 0) begin inst_data_ok_i = 1; inst_rdata_i = mem(paddr); pending = 0; end
        end else if (inst_req_o) begin
          if (hold_left > 0) hold_left--;
          else begin inst_addr_ok_i = 1; acc_addr = inst_addr_o; hold_left = hold_cfg; end
        end
      end
    end
  end

  // Request monitor: every accepted fetch address must match the next expected one.
  initial begin : req_mon
    forever begin
      @(negedge clk_i); #2;
      if (rst_i && inst_req_o && inst_addr_ok_i) begin
        if (exp_req.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_req: got %h, required none", inst_addr_o);
        end else chk("req_addr", inst_addr_o, exp_req.pop_front());
      end
    end
  end

  // Output monitor: an instruction is consumed when it is valid and not stalled. Bubbles must be all zero.
  initial begin : out_mon
    out_t e;
    forever begin
      @(negedge clk_i); #2;
      if (if_valid_o && !stall_i) begin
        if (exp_out.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_out: got pc %h inst %h, required none", if_pc_o, if_inst_o);
        end else begin
          e = exp_out.pop_front();
          chk("out_pc", if_pc_o, e.pc);
          chk("out_inst", if_inst_o, e.inst);
          chk("out_adel", {31'd0, if_adel_o}, {31'd0, e.adel});
        end
      end else if (!if_valid_o) begin
        chk("bubble", if_pc_o | if_inst_o | {31'd0, if_adel_o}, 32'd0);
      end
    end
  end

  initial begin : main
    rst_i = 0; stall_i = 1; branch_valid_i = 0; branch_target_i = 0;
    repeat (2) @(negedge clk_i);
    #2;
    chk("rst_req", {31'd0, inst_req_o}, 32'd0);
    chk("rst_addr", inst_addr_o, RST_PC);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);

    // First fetch after reset, then park it under stall.
    exp_req.push_back(RST_PC);
    exp_out.push_back(out_t'{pc: RST_PC, inst: 32'h2408_0001, adel: 1'b0});
    @(negedge clk_i); rst_i = 1;
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #2;
      chk("stall_valid", {31'd0, if_valid_o}, 32'd1);
      chk("stall_pc", if_pc_o, RST_PC);
      chk("stall_inst", if_inst_o, 32'h2408_0001);
      chk("stall_req", {31'd0, inst_req_o}, 32'd0);
    end

    // Release: request pc+4 next cycle, then redirect while it is in flight.
    exp_req.push_back(RST_PC + 32'd4);
    data_lat = 2;
    @(negedge clk_i); stall_i = 0;
    @(negedge clk_i); stall_i = 1; #2;
    chk("req_after_stall", {31'd0, inst_req_o}, 32'd1);
    chk("addr_after_stall", inst_addr_o, RST_PC + 32'd4);
    @(negedge clk_i); branch_valid_i = 1; branch_target_i = 32'hBFC0_0100;
    exp_req.push_back(32'hBFC0_0100);
    exp_out.push_back(out_t'{pc: 32'hBFC0_0100, inst: 32'h3C01_1234, adel: 1'b0});
    @(negedge clk_i); branch_valid_i = 0; data_lat = 1; #2;
    chk("dropped_valid", {31'd0, if_valid_o}, 32'd0);
    @(negedge clk_i); #2;
    chk("redir_req", {31'd0, inst_req_o}, 32'd1);
    chk("redir_addr", inst_addr_o, 32'hBFC0_0100);
    wait_valid();

    // Consume 0x100, fetch 0x104, then flush 0x104 with a misaligned redirect.
    exp_req.push_back(32'hBFC0_0104);
    @(negedge clk_i); stall_i = 0;
    @(negedge clk_i); stall_i = 1;
    wait_valid();
    @(negedge clk_i); branch_valid_i = 1; branch_target_i = 32'hBFC0_0102; #2;
    chk("flush_valid", {31'd0, if_valid_o}, 32'd0);
    @(negedge clk_i); branch_valid_i = 0; #2;
    chk("adel_noreq", {31'd0, inst_req_o}, 32'd0);
    @(negedge clk_i); #2;
    chk("adel_flag", {31'd0, if_adel_o}, 32'd1);
    exp_out.push_back(out_t'{pc: 32'hBFC0_0102, inst: 32'd0, adel: 1'b1});
    @(negedge clk_i); stall_i = 0;
    @(negedge clk_i); stall_i = 1; #2;
    chk("adel2_noreq", {31'd0, inst_req_o}, 32'd0);

    // Redirect to the top of the address space and wrap to zero.
    @(negedge clk_i); branch_valid_i = 1; branch_target_i = 32'hFFFF_FFFC;
    exp_req.push_back(32'hFFFF_FFFC);
    exp_out.push_back(out_t'{pc: 32'hFFFF_FFFC, inst: 32'h1000_FFFF, adel: 1'b0});
    @(negedge clk_i); branch_valid_i = 0;
    wait_valid();
    exp_req.push_back(32'h0000_0000);
    exp_out.push_back(out_t'{pc: 32'h0000_0000, inst: 32'h2402_0000, adel: 1'b0});
    @(negedge clk_i); stall_i = 0;
    @(negedge clk_i); stall_i = 1; #2;
    chk("wrap_addr", inst_addr_o, 32'h0000_0000);
    wait_valid();

    // addr_ok withheld 5 cycles, then reset while waiting for data.
    hold_cfg = 0; hold_left = 5; data_lat = 3;
    exp_req.push_back(32'h0000_0004);
    @(negedge clk_i); stall_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); stall_i = 1; #2;
      chk("hold_req", {31'd0, inst_req_o}, 32'd1);
      chk("hold_addr", inst_addr_o, 32'h0000_0004);
    end
    wait_accept();
    @(negedge clk_i); rst_i = 0; #2;
    chk("midrst_req", {31'd0, inst_req_o}, 32'd0);
    chk("midrst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("midrst_addr", inst_addr_o, RST_PC);
    @(negedge clk_i);
    @(negedge clk_i);
    data_lat = 1;
    exp_req.push_back(RST_PC);
    exp_out.push_back(out_t'{pc: RST_PC, inst: 32'h2408_0001, adel: 1'b0});
    rst_i = 1;
    wait_valid();
    exp_req.push_back(RST_PC + 32'd4);
    @(negedge clk_i); stall_i = 0;
    @(negedge clk_i); stall_i = 1;
    repeat (4) @(negedge clk_i);
    #2;
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("out_queue_empty", exp_out.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
